// File: rtl/vga_monitor.sv
// VGA timing monitor: locks onto an hsync/vsync stream, tracks frame health,
// and republishes active pixels with coordinates plus a single-point colour probe.
module vga_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_25mhz,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  input  logic [9:0]  probe_x,
  input  logic [8:0]  probe_y,
  output logic        locked,
  output logic        frame_start,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic [23:0] probe_rgb,
  output logic        probe_hit,
  output logic [15:0] err_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SLEN = 11'(H_SYNC);
  localparam logic [10:0] H_A0   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_A1   = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] V_TOT  = 11'(V_TOTAL);
  localparam logic [9:0]  V_A0   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_A1   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [23:0] rgb_q;
  logic [9:0]  probe_x_q;
  logic [8:0]  probe_y_q;
  logic [10:0] h_cnt_q, h_cnt_d, lo_cnt_q, lo_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        line_err_q, line_err_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  state_t      state_q, state_d;
  logic        hfall, hrise, vfall, line_err_now, frame_err, h_sat;
  logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic        probe_hit_q, probe_hit_d;
  logic [9:0]  pix_x_q, pix_x_d, col;
  logic [8:0]  pix_y_q, pix_y_d, row;
  logic [23:0] pix_rgb_q, pix_rgb_d, probe_rgb_q, probe_rgb_d;

  // Input sample stage; sync levels idle high so reset never fakes an edge.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      rgb_q     <= '0;
      probe_x_q <= '0;
      probe_y_q <= '0;
    end else begin
      hs_q      <= hsync;
      vs_q      <= vsync;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      rgb_q     <= {red, green, blue};
      probe_x_q <= probe_x;
      probe_y_q <= probe_y;
    end
  end

  assign hfall = hs_prev_q & ~hs_q;
  assign hrise = ~hs_prev_q & hs_q;
  assign vfall = vs_prev_q & ~vs_q;

  // Counters describe the current sample; the _q copies belong to the previous one.
  always_comb begin
    h_cnt_d      = hfall ? 11'd0 : ((h_cnt_q == 11'h7FF) ? h_cnt_q : h_cnt_q + 11'd1);
    v_cnt_d      = vfall ? 10'd0 : ((v_cnt_q == 10'h3FF) ? v_cnt_q : v_cnt_q + {9'd0, hfall});
    lo_cnt_d     = hs_q ? 11'd0 : ((lo_cnt_q == 11'h7FF) ? lo_cnt_q : lo_cnt_q + 11'd1);
    line_err_now = (hfall && h_cnt_q != H_LAST) || (hrise && lo_cnt_q != H_SLEN);
    frame_err    = line_err_q || line_err_now || (({1'b0, v_cnt_q} + {10'd0, hfall}) != V_TOT);
    line_err_d   = vfall ? 1'b0 : (line_err_q | line_err_now);
    h_sat        = (h_cnt_d == 11'h7FF);
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      lo_cnt_q   <= '0;
      line_err_q <= 1'b0;
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
      state_q    <= SEARCH;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      lo_cnt_q   <= lo_cnt_d;
      line_err_q <= line_err_d;
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      SEARCH: if (vfall) begin
        state_d    = TRACK;
        good_cnt_d = '0;
      end
      TRACK: if (vfall) begin
        if (frame_err) begin
          good_cnt_d = '0;
        end else begin
          good_cnt_d = good_cnt_q + 8'd1;
          if (good_cnt_q + 8'd1 >= LOCK_N) state_d = LOCKED;
        end
      end
      LOCKED: if (vfall && frame_err) begin
        state_d    = TRACK;
        good_cnt_d = '0;
        err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
      end
      default: state_d = SEARCH;
    endcase
    // A missing hsync overrides everything, including the error count.
    if (h_sat) begin
      state_d    = SEARCH;
      good_cnt_d = '0;
      err_cnt_d  = err_cnt_q;
    end
  end

  always_comb begin
    col           = 10'(h_cnt_d - H_A0);
    row           = 9'(v_cnt_d - V_A0);
    pix_valid_d   = (state_d == LOCKED) && (h_cnt_d >= H_A0) && (h_cnt_d <= H_A1) &&
                    (v_cnt_d >= V_A0) && (v_cnt_d <= V_A1);
    frame_start_d = vfall && (state_q == LOCKED) && (state_d == LOCKED);
    pix_x_d       = pix_valid_d ? col : pix_x_q;
    pix_y_d       = pix_valid_d ? row : pix_y_q;
    pix_rgb_d     = pix_valid_d ? rgb_q : pix_rgb_q;
    probe_hit_d   = pix_valid_d && (col == probe_x_q) && (row == probe_y_q);
    probe_rgb_d   = probe_hit_d ? rgb_q : probe_rgb_q;
  end

  // Output stage: second clock of pin-to-output latency.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      probe_hit_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      probe_rgb_q   <= '0;
    end else begin
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      probe_hit_q   <= probe_hit_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      probe_rgb_q   <= probe_rgb_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign frame_start = frame_start_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign probe_rgb   = probe_rgb_q;
  assign probe_hit   = probe_hit_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_vga_monitor.sv
// Directed bench for vga_monitor using a shrunken raster (15x8 clocks, 8x4 active)
// so whole-frame scenarios stay short.
module tb_vga_monitor;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int H0 = HS + HB;
  localparam int V0 = VS + VB;

  logic        clk = 1'b0;
  logic        rst_n, hsync, vsync;
  logic [7:0]  red, green, blue;
  logic [9:0]  probe_x;
  logic [8:0]  probe_y;
  logic        locked, frame_start, pix_valid, probe_hit;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [23:0] pix_rgb, probe_rgb;
  logic [15:0] err_count;

  int vec = 0, bad = 0;
  int hp_c = -100, hp_d1 = -100, hp_d2 = -100;
  int vp_c = -100, vp_d1 = -100, vp_d2 = -100;
  int pv_cnt = 0, hit_cnt = 0, fs_cnt = 0;
  int rgb_bad = 0, align_bad = 0, hit_bad = 0, fs_bad = 0;
  int pv0, hit0, fs0;

  always #20 clk = ~clk;

  vga_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .LOCK_FRAMES(2)
  ) dut (
    .clk_25mhz(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .probe_x(probe_x), .probe_y(probe_y),
    .locked(locked), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .probe_rgb(probe_rgb),
    .probe_hit(probe_hit), .err_count(err_count)
  );

  // Output monitor: outputs must reflect the pins driven two clocks earlier.
  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      pv_cnt <= pv_cnt + 1;
      if (pix_rgb !== ((pix_x == 10'd7 && pix_y == 9'd3) ? 24'h123456 : 24'hFF0000))
        rgb_bad <= rgb_bad + 1;
      if (pix_x !== 10'(hp_d2 - H0) || pix_y !== 9'(vp_d2 - V0))
        align_bad <= align_bad + 1;
    end
    if (probe_hit === 1'b1) begin
      hit_cnt <= hit_cnt + 1;
      if (!(pix_valid === 1'b1 && pix_x == 10'd7 && pix_y == 9'd3 && probe_rgb === 24'h123456))
        hit_bad <= hit_bad + 1;
    end
    if (frame_start === 1'b1) begin
      fs_cnt <= fs_cnt + 1;
      if (hp_d2 != 0 || vp_d2 != 0) fs_bad <= fs_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input int hp, input int vp);
    logic act;
    act   = (hp >= H0) && (hp < H0 + HA) && (vp >= V0) && (vp < V0 + VA);
    hsync = (hp >= HS);
    vsync = (vp >= VS);
    {red, green, blue} = !act ? 24'h0 :
                         ((hp == H0 + 7 && vp == V0 + 3) ? 24'h123456 : 24'hFF0000);
    hp_d2 = hp_d1; hp_d1 = hp_c; hp_c = hp;
    vp_d2 = vp_d1; vp_d1 = vp_c; vp_c = vp;
  endtask

  task automatic drive_lines(input int first, input int last, input int long_line);
    for (int vp = first; vp <= last; vp++) begin
      for (int hp = 0; hp < ((vp == long_line) ? HT + 1 : HT); hp++) begin
        step();
        set_pins(hp, vp);
      end
    end
  endtask

  task automatic frame();
    drive_lines(0, VT - 1, -1);
  endtask

  initial begin
    rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1;
    red = '0; green = '0; blue = '0;
    probe_x = 10'd7; probe_y = 9'd3;
    repeat (3) step();
    chk("reset_locked", 32'(locked), 0);
    chk("reset_pix_valid", 32'(pix_valid), 0);
    chk("reset_frame_start", 32'(frame_start), 0);
    chk("reset_pix_rgb", 32'(pix_rgb), 0);
    chk("reset_err_count", 32'(err_count), 0);
    chk("reset_probe_hit", 32'(probe_hit), 0);
    rst_n = 1'b1;

    // Acquire lock: third vfall enters LOCKED.
    frame(); frame();
    chk("unlocked_after_2_vfalls", 32'(locked), 0);
    frame();
    chk("locked_after_3_vfalls", 32'(locked), 1);

    pv0 = pv_cnt; hit0 = hit_cnt; fs0 = fs_cnt;
    frame(); frame();
    chk("pix_valid_per_2_frames", 32'(pv_cnt - pv0), 2 * HA * VA);
    chk("probe_hits_2_frames", 32'(hit_cnt - hit0), 2);
    chk("frame_starts_2_frames", 32'(fs_cnt - fs0), 2);
    chk("probe_rgb", 32'(probe_rgb), 32'h123456);
    chk("hold_pix_x", 32'(pix_x), 7);
    chk("hold_pix_y", 32'(pix_y), 3);
    chk("hold_pix_rgb", 32'(pix_rgb), 32'h123456);
    chk("blank_pix_valid", 32'(pix_valid), 0);
    chk("clean_err_count", 32'(err_count), 0);

    // One line one clock long.
    drive_lines(0, VT - 1, 4);
    chk("long_line_still_locked", 32'(locked), 1);
    fs0 = fs_cnt;
    frame();
    chk("long_line_unlock", 32'(locked), 0);
    chk("long_line_err_count", 32'(err_count), 1);
    frame();
    chk("long_line_relock_pending", 32'(locked), 0);
    frame();
    chk("long_line_relocked", 32'(locked), 1);
    chk("no_fs_during_relock", 32'(fs_cnt - fs0), 0);

    // Frame one line short.
    drive_lines(0, VT - 2, -1);
    fs0 = fs_cnt;
    frame();
    chk("short_frame_unlock", 32'(locked), 0);
    chk("short_frame_err_count", 32'(err_count), 2);
    chk("short_frame_no_fs", 32'(fs_cnt - fs0), 0);
    frame();
    chk("short_frame_relock_pending", 32'(locked), 0);
    frame();
    chk("short_frame_relocked", 32'(locked), 1);

    // hsync stuck high until h_cnt saturates.
    for (int j = 1; j <= 2048; j++) begin
      step();
      if (j == 2034) chk("sat_minus1_locked", 32'(locked), 1);
      if (j == 2035) chk("sat_unlocked", 32'(locked), 0);
      set_pins(1000, 1000);
    end
    chk("sat_err_count", 32'(err_count), 2);
    frame(); frame(); frame();
    chk("sat_relocked", 32'(locked), 1);
    chk("sat_relock_err_count", 32'(err_count), 2);

    // Asynchronous reset mid-frame.
    drive_lines(0, 3, -1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_locked", 32'(locked), 0);
    chk("async_rst_pix_x", 32'(pix_x), 0);
    chk("async_rst_probe_rgb", 32'(probe_rgb), 0);
    chk("async_rst_err_count", 32'(err_count), 0);
    drive_lines(4, 5, -1);
    rst_n = 1'b1;
    drive_lines(6, VT - 1, -1);
    frame(); frame();
    chk("post_rst_2_vfalls", 32'(locked), 0);
    frame();
    chk("post_rst_3_vfalls", 32'(locked), 1);
    chk("post_rst_err_count", 32'(err_count), 0);

    step();
    chk("pix_rgb_errors", 32'(rgb_bad), 0);
    chk("pix_alignment_errors", 32'(align_bad), 0);
    chk("probe_hit_errors", 32'(hit_bad), 0);
    chk("frame_start_alignment", 32'(fs_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
